// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: stall bit positions,
// FSM state types and the exception polarity.
package pipe_stall_ctrl_pkg;

  localparam int STALL_INST = 0;
  localparam int STALL_ID   = 1;
  localparam int STALL_EXE  = 2;
  localparam int STALL_DATA = 3;
  localparam int STALL_W    = 4;

  localparam logic EXCEPTION_ON = 1'b1;

  typedef enum logic [1:0] {
    I_IDLE   = 2'd0,
    I_WAIT   = 2'd1,
    I_CANCEL = 2'd2
  } inst_state_e;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_WAIT = 1'b1
  } data_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline stages / SRAM ports and the stall sequencer.
interface pipe_stall_ctrl_if;
  logic       inst_req;
  logic       inst_addr_ok;
  logic       inst_data_ok;
  logic       data_req;
  logic       data_addr_ok;
  logic       data_data_ok;
  logic       id_load_use;
  logic       ex_div_start;
  logic       exception_in;
  logic [3:0] stall;
  logic       flush;
  logic       div_done;
  logic       inst_discard;

  modport master (
    output inst_req, inst_addr_ok, inst_data_ok,
    output data_req, data_addr_ok, data_data_ok,
    output id_load_use, ex_div_start, exception_in,
    input  stall, flush, div_done, inst_discard
  );

  modport slave (
    input  inst_req, inst_addr_ok, inst_data_ok,
    input  data_req, data_addr_ok, data_data_ok,
    input  id_load_use, ex_div_start, exception_in,
    output stall, flush, div_done, inst_discard
  );
endinterface

// File: rtl/pipe_stall_ctrl_sram_txn_tracker.sv
// Tracks one outstanding SRAM-like transaction and raises stall while the
// address is not yet accepted or the response is still pending.
module sram_txn_tracker
  import pipe_stall_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic addr_ok_i,
  input  logic data_ok_i,
  output logic stall_o
);

  data_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= D_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    case (state_q)
      D_IDLE: begin
        stall_o = req_i & ~addr_ok_i;
        if (req_i && addr_ok_i) state_d = D_WAIT;
      end
      D_WAIT: begin
        stall_o = ~data_ok_i;
        if (data_ok_i) state_d = D_IDLE;
      end
      default: state_d = D_IDLE;
    endcase
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: fetch tracking with post-exception
// response discard, data-access tracking, divide timing and load-use bubble qualification.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 33
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stall_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  inst_state_e      inst_q, inst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush;
  logic             inst_stall, data_stall, div_stall, id_stall;
  logic             discard;

  assign flush = (bus.exception_in == EXCEPTION_ON);

  // Data accesses are never cancelled: a store already issued must complete.
  sram_txn_tracker u_data_trk (
    .clk       (clk),
    .rst       (rst),
    .req_i     (bus.data_req),
    .addr_ok_i (bus.data_addr_ok),
    .data_ok_i (bus.data_data_ok),
    .stall_o   (data_stall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q <= I_IDLE;
      cnt_q  <= '0;
    end else begin
      inst_q <= inst_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    inst_d     = inst_q;
    inst_stall = 1'b0;
    discard    = 1'b0;
    case (inst_q)
      I_IDLE: begin
        inst_stall = bus.inst_req & ~bus.inst_addr_ok;
        if (bus.inst_req && bus.inst_addr_ok) inst_d = I_WAIT;
      end
      I_WAIT: begin
        inst_stall = ~bus.inst_data_ok;
        if (bus.inst_data_ok) inst_d = I_IDLE;
        else if (flush)       inst_d = I_CANCEL;
      end
      I_CANCEL: begin
        // The response to a fetch issued before the exception belongs to the dead path.
        inst_stall = 1'b1;
        discard    = bus.inst_data_ok;
        if (bus.inst_data_ok) inst_d = I_IDLE;
      end
      default: inst_d = I_IDLE;
    endcase
  end

  // Count DIV_CYCLES-1 down to 1; a start seen while busy is the same divide held in EX.
  always_comb begin
    cnt_d = cnt_q;
    if (flush)                                cnt_d = '0;
    else if (cnt_q != '0)                     cnt_d = cnt_q - CNT_W'(1);
    else if (bus.ex_div_start)                cnt_d = CNT_W'(DIV_CYCLES - 1);
  end

  assign div_stall = (bus.ex_div_start && cnt_q == '0) || (cnt_q > CNT_W'(1));
  // A bubble must not overwrite an EX instruction that is being held.
  assign id_stall  = bus.id_load_use & ~div_stall & ~data_stall;

  always_comb begin
    bus.stall             = '0;
    bus.stall[STALL_INST] = inst_stall & ~flush;
    bus.stall[STALL_ID]   = id_stall   & ~flush;
    bus.stall[STALL_EXE]  = div_stall  & ~flush;
    bus.stall[STALL_DATA] = data_stall;
  end

  assign bus.flush        = flush;
  assign bus.div_done     = (cnt_q == CNT_W'(1));
  assign bus.inst_discard = discard;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: fetch, divide, cancel, hazard masking,
// exception mid-divide and reset from busy states, with hand-computed expectations.
module tb_pipe_stall_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pipe_stall_ctrl_if bus ();

  pipe_stall_ctrl #(.DIV_CYCLES(33)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change there, checks follow #1 later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_in();
    bus.inst_req = 0; bus.inst_addr_ok = 0; bus.inst_data_ok = 0;
    bus.data_req = 0; bus.data_addr_ok = 0; bus.data_data_ok = 0;
    bus.id_load_use = 0; bus.ex_div_start = 0; bus.exception_in = 0;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] st, input logic fl,
                         input logic dd, input logic dis);
    #1;
    chk({tag, ".stall"}, {4'h0, bus.stall}, {4'h0, st});
    chk({tag, ".flush"}, {7'h0, bus.flush}, {7'h0, fl});
    chk({tag, ".div_done"}, {7'h0, bus.div_done}, {7'h0, dd});
    chk({tag, ".discard"}, {7'h0, bus.inst_discard}, {7'h0, dis});
  endtask

  initial begin
    zero_in();
    rst = 1;
    cyc(); cyc();
    chk_all("reset", 4'b0000, 0, 0, 0);
    rst = 0;

    // Fetch: addr stalled one cycle, accepted, data at +3
    cyc(); bus.inst_req = 1;                        chk_all("fetch_noack", 4'b0001, 0, 0, 0);
    cyc(); bus.inst_addr_ok = 1;                    chk_all("fetch_c0", 4'b0000, 0, 0, 0);
    cyc(); zero_in();                               chk_all("fetch_c1", 4'b0001, 0, 0, 0);
    cyc();                                          chk_all("fetch_c2", 4'b0001, 0, 0, 0);
    cyc(); bus.inst_data_ok = 1;                    chk_all("fetch_c3", 4'b0000, 0, 0, 0);
    cyc(); zero_in();                               chk_all("fetch_c4", 4'b0000, 0, 0, 0);

    // Divide: start at cycle 0, spurious start at cycle 5
    cyc(); bus.ex_div_start = 1;                    chk_all("div_c0", 4'b0100, 0, 0, 0);
    for (int c = 1; c < 32; c++) begin
      cyc(); bus.ex_div_start = (c == 5);
      chk_all("div_busy", 4'b0100, 0, 0, 0);
    end
    cyc(); bus.ex_div_start = 0;                    chk_all("div_c32", 4'b0000, 0, 1, 0);
    cyc();                                          chk_all("div_c33", 4'b0000, 0, 0, 0);

    // Cancel: exception while fetch outstanding, late response discarded
    cyc(); bus.inst_req = 1; bus.inst_addr_ok = 1;  chk_all("cxl_c0", 4'b0000, 0, 0, 0);
    cyc(); zero_in(); bus.exception_in = 1;         chk_all("cxl_c1", 4'b0000, 1, 0, 0);
    cyc(); zero_in();                               chk_all("cxl_c2", 4'b0001, 0, 0, 0);
    cyc(); bus.inst_req = 1; bus.inst_addr_ok = 1;  chk_all("cxl_c3", 4'b0001, 0, 0, 0);
    cyc(); zero_in(); bus.inst_data_ok = 1;         chk_all("cxl_c4", 4'b0001, 0, 0, 1);
    cyc(); zero_in();                               chk_all("cxl_c5", 4'b0000, 0, 0, 0);

    // Exception coincident with data_ok in I_WAIT: no cancel, no discard
    cyc(); bus.inst_req = 1; bus.inst_addr_ok = 1;  chk_all("sim_c0", 4'b0000, 0, 0, 0);
    cyc(); zero_in(); bus.exception_in = 1; bus.inst_data_ok = 1;
                                                    chk_all("sim_c1", 4'b0000, 1, 0, 0);
    cyc(); zero_in();                               chk_all("sim_c2", 4'b0000, 0, 0, 0);
    cyc(); bus.inst_data_ok = 1;                    chk_all("sim_c3", 4'b0000, 0, 0, 0);

    // Hazard masking by the data side
    cyc(); zero_in(); bus.data_req = 1; bus.id_load_use = 1;
                                                    chk_all("haz_c0", 4'b1000, 0, 0, 0);
    cyc(); bus.data_addr_ok = 1;                    chk_all("haz_c1", 4'b0010, 0, 0, 0);
    cyc(); bus.data_req = 0; bus.data_addr_ok = 0;  chk_all("haz_c2", 4'b1000, 0, 0, 0);
    cyc(); bus.data_data_ok = 1;                    chk_all("haz_c3", 4'b0010, 0, 0, 0);
    cyc(); zero_in();                               chk_all("haz_c4", 4'b0000, 0, 0, 0);
    // Hazard masked by divide start, then by flush
    cyc(); bus.id_load_use = 1; bus.ex_div_start = 1;
                                                    chk_all("haz_div", 4'b0100, 0, 0, 0);
    cyc(); zero_in(); bus.id_load_use = 1; bus.exception_in = 1;
                                                    chk_all("haz_flush", 4'b0000, 1, 0, 0);
    cyc(); zero_in();                               chk_all("haz_after", 4'b0000, 0, 0, 0);

    // Exception does not cancel an issued data access
    cyc(); bus.data_req = 1; bus.data_addr_ok = 1;  chk_all("dx_c0", 4'b0000, 0, 0, 0);
    cyc(); zero_in(); bus.exception_in = 1;         chk_all("dx_c1", 4'b1000, 1, 0, 0);
    cyc(); zero_in();                               chk_all("dx_c2", 4'b1000, 0, 0, 0);
    cyc(); bus.data_data_ok = 1;                    chk_all("dx_c3", 4'b0000, 0, 0, 0);
    cyc(); zero_in();                               chk_all("dx_c4", 4'b0000, 0, 0, 0);

    // Exception mid-divide at cnt=10 (cycle 23 after start)
    cyc(); bus.ex_div_start = 1;                    chk_all("mdx_c0", 4'b0100, 0, 0, 0);
    for (int c = 1; c < 23; c++) begin
      cyc(); bus.ex_div_start = 0;
      chk_all("mdx_busy", 4'b0100, 0, 0, 0);
    end
    cyc(); bus.exception_in = 1;                    chk_all("mdx_c23", 4'b0000, 1, 0, 0);
    for (int c = 24; c < 36; c++) begin
      cyc(); zero_in();
      chk_all("mdx_after", 4'b0000, 0, 0, 0);
    end
    // Counter really cleared: a fresh divide runs a full 32 stall cycles
    cyc(); bus.ex_div_start = 1;                    chk_all("mdx_new0", 4'b0100, 0, 0, 0);
    for (int c = 1; c < 32; c++) begin
      cyc(); bus.ex_div_start = 0;
      chk_all("mdx_new", 4'b0100, 0, 0, 0);
    end
    cyc();                                          chk_all("mdx_new32", 4'b0000, 0, 1, 0);

    // Reset while inst is in I_CANCEL and data in D_WAIT
    cyc(); zero_in(); bus.inst_req = 1; bus.inst_addr_ok = 1;
    bus.data_req = 1; bus.data_addr_ok = 1;         chk_all("rst_c0", 4'b0000, 0, 0, 0);
    cyc(); zero_in(); bus.exception_in = 1;         chk_all("rst_c1", 4'b1000, 1, 0, 0);
    cyc(); zero_in(); rst = 1;                      chk_all("rst_c2", 4'b1001, 0, 0, 0);
    cyc(); rst = 0;                                 chk_all("rst_c3", 4'b0000, 0, 0, 0);
    cyc(); bus.inst_data_ok = 1; bus.data_data_ok = 1;
                                                    chk_all("rst_c4", 4'b0000, 0, 0, 0);
    cyc(); zero_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
